// File: rtl/lcd_types_pkg.sv
// Shared types for the LCD port: bus-engine state encoding, default strobe
// timings and the request bundle coming from the init/id mux.
package lcd_types;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_LO,
        ST_WR_HI,
        ST_RD_LO,
        ST_RD_HI,
        ST_DONE
    } lcd_bus_state_t;

    localparam int unsigned LCD_WR_LOW_CYC  = 2;
    localparam int unsigned LCD_WR_HIGH_CYC = 2;
    localparam int unsigned LCD_RD_LOW_CYC  = 8;
    localparam int unsigned LCD_RD_HIGH_CYC = 8;

    typedef struct packed {
        logic [15:0] data;
        logic        we;
        logic        wr;
        logic        lcd_rs;
        logic        id_fm;
        logic        read_color;
    } interface_mux_struct;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each strobe phase; holds at zero.
module lcd_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// 8080-style 16-bit LCD bus timing engine. Every output is registered from the
// next-state decode so strobes line up exactly with the FSM state.
module lcd_bus_driver
    import lcd_types::*;
#(
    parameter int unsigned WR_LOW_CYC  = LCD_WR_LOW_CYC,
    parameter int unsigned WR_HIGH_CYC = LCD_WR_HIGH_CYC,
    parameter int unsigned RD_LOW_CYC  = LCD_RD_LOW_CYC,
    parameter int unsigned RD_HIGH_CYC = LCD_RD_HIGH_CYC,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        wr,
    input  logic        lcd_rs,
    input  logic [15:0] data,
    input  logic        id_fm,
    input  logic        read_color,
    output logic        busy,
    output logic        write_color_ok,
    output logic        init_write_ok,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        lcd_cs_n,
    output logic        lcd_rs_o,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data_o,
    output logic        lcd_data_oe,
    input  logic [15:0] lcd_data_i
);

    localparam logic [CNT_W-1:0] WR_LO_LD = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WR_HI_LD = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LO_LD = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RD_HI_LD = CNT_W'(RD_HIGH_CYC - 1);

    lcd_bus_state_t state_q, state_d;
    logic        wr_q, wr_d, rs_q, rs_d;
    logic [15:0] data_q, data_d, sample_q;
    logic [1:0]  words_q, words_d;
    logic        tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    logic        busy_d, cs_n_d, rs_o_d, wr_n_d, rd_n_d, oe_d;
    logic        init_ok_d, color_ok_d, rvalid_d;
    logic [15:0] data_o_d, rdata_d;

    lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rs_d    = rs_q;
        data_d  = data_q;
        words_d = words_q;
        case (state_q)
            ST_IDLE: if (we) begin
                state_d = ST_SETUP;
                wr_d    = wr;
                rs_d    = lcd_rs;
                data_d  = data;
                words_d = (!wr && (read_color || id_fm)) ? 2'd2 : 2'd1;
            end
            ST_SETUP: state_d = wr_q ? ST_WR_LO : ST_RD_LO;
            ST_WR_LO: if (tmr_zero) state_d = ST_WR_HI;
            ST_WR_HI: if (tmr_zero) state_d = ST_DONE;
            ST_RD_LO: if (tmr_zero) state_d = ST_RD_HI;
            ST_RD_HI: if (tmr_zero) begin
                words_d = words_q - 2'd1;
                state_d = (words_q == 2'd1) ? ST_DONE : ST_RD_LO;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        tmr_load = (state_d != state_q);
        case (state_d)
            ST_WR_LO: tmr_val = WR_LO_LD;
            ST_WR_HI: tmr_val = WR_HI_LD;
            ST_RD_LO: tmr_val = RD_LO_LD;
            ST_RD_HI: tmr_val = RD_HI_LD;
            default:  tmr_val = '0;
        endcase

        // Outputs decode the upcoming state, using the freshly latched request
        // so SETUP already shows RS/data on the cycle right after acceptance.
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        cs_n_d     = !busy_d;
        rs_o_d     = (state_d != ST_IDLE) ? rs_d : 1'b0;
        wr_n_d     = (state_d != ST_WR_LO);
        rd_n_d     = (state_d != ST_RD_LO);
        oe_d       = wr_d && ((state_d == ST_SETUP) || (state_d == ST_WR_LO) ||
                              (state_d == ST_WR_HI));
        data_o_d   = oe_d ? data_d : '0;
        init_ok_d  = (state_d == ST_DONE) && wr_d;
        color_ok_d = init_ok_d && rs_d;
        rvalid_d   = (state_d == ST_DONE) && !wr_d;
        rdata_d    = rvalid_d ? sample_q : rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_q           <= 1'b0;
            rs_q           <= 1'b0;
            data_q         <= '0;
            words_q        <= '0;
            sample_q       <= '0;
            busy           <= 1'b0;
            lcd_cs_n       <= 1'b1;
            lcd_rs_o       <= 1'b0;
            lcd_wr_n       <= 1'b1;
            lcd_rd_n       <= 1'b1;
            lcd_data_oe    <= 1'b0;
            lcd_data_o     <= '0;
            init_write_ok  <= 1'b0;
            write_color_ok <= 1'b0;
            rdata_valid    <= 1'b0;
            rdata          <= '0;
        end else begin
            state_q        <= state_d;
            wr_q           <= wr_d;
            rs_q           <= rs_d;
            data_q         <= data_d;
            words_q        <= words_d;
            if ((state_q == ST_RD_LO) && tmr_zero) begin
                sample_q <= lcd_data_i;
            end
            busy           <= busy_d;
            lcd_cs_n       <= cs_n_d;
            lcd_rs_o       <= rs_o_d;
            lcd_wr_n       <= wr_n_d;
            lcd_rd_n       <= rd_n_d;
            lcd_data_oe    <= oe_d;
            lcd_data_o     <= data_o_d;
            init_write_ok  <= init_ok_d;
            write_color_ok <= color_ok_d;
            rdata_valid    <= rvalid_d;
            rdata          <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver: cycle-accurate strobe and pulse checks.
module tb_lcd_bus_driver;

    localparam int WRL = 2;
    localparam int WRH = 2;
    localparam int RDL = 8;
    localparam int RDH = 8;

    logic        clk = 1'b0;
    logic        rst_n, we, wr, lcd_rs, id_fm, read_color;
    logic [15:0] data, lcd_data_i;
    logic        busy, write_color_ok, init_write_ok, rdata_valid;
    logic        lcd_cs_n, lcd_rs_o, lcd_wr_n, lcd_rd_n, lcd_data_oe;
    logic [15:0] rdata, lcd_data_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lcd_bus_driver #(
        .WR_LOW_CYC  (WRL),
        .WR_HIGH_CYC (WRH),
        .RD_LOW_CYC  (RDL),
        .RD_HIGH_CYC (RDH),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .we             (we),
        .wr             (wr),
        .lcd_rs         (lcd_rs),
        .data           (data),
        .id_fm          (id_fm),
        .read_color     (read_color),
        .busy           (busy),
        .write_color_ok (write_color_ok),
        .init_write_ok  (init_write_ok),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .lcd_cs_n       (lcd_cs_n),
        .lcd_rs_o       (lcd_rs_o),
        .lcd_wr_n       (lcd_wr_n),
        .lcd_rd_n       (lcd_rd_n),
        .lcd_data_o     (lcd_data_o),
        .lcd_data_oe    (lcd_data_oe),
        .lcd_data_i     (lcd_data_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is in cycle 0 (just after an edge); returns in the DONE cycle.
    task automatic run_txn(input string name, input logic twr, input logic trs,
                           input logic [15:0] tdata, input logic tid, input logic trc,
                           input logic [15:0] b1, input logic [15:0] b2, input int we_at);
        int n;
        int last;
        logic [15:0] exp_rd;
        n      = (!twr && (tid || trc)) ? 2 : 1;
        last   = twr ? 2 + WRL + WRH : 2 + n * (RDL + RDH);
        exp_rd = (n == 2) ? b2 : b1;
        we = 1'b1; wr = twr; lcd_rs = trs; data = tdata; id_fm = tid; read_color = trc;
        for (int k = 1; k <= last; k++) begin
            step();
            we = (k == we_at);
            if (k == we_at) begin
                wr = 1'b1; lcd_rs = 1'b1; data = 16'hDEAD;
            end
            lcd_data_i = (((k - 2) / (RDL + RDH)) == 0) ? b1 : b2;
            check($sformatf("%s c%0d busy", name, k), busy, (k < last));
            check($sformatf("%s c%0d cs_n", name, k), lcd_cs_n, !(k < last));
            check($sformatf("%s c%0d rs_o", name, k), lcd_rs_o, trs);
            check($sformatf("%s c%0d wr_n", name, k), lcd_wr_n,
                  !(twr && k >= 2 && k <= 1 + WRL));
            check($sformatf("%s c%0d rd_n", name, k), lcd_rd_n,
                  !(!twr && k >= 2 && k < last && ((k - 2) % (RDL + RDH)) < RDL));
            check($sformatf("%s c%0d oe", name, k), lcd_data_oe, twr && k < last);
            if (twr && k < last)
                check($sformatf("%s c%0d data_o", name, k), lcd_data_o, tdata);
            check($sformatf("%s c%0d init_ok", name, k), init_write_ok, twr && k == last);
            check($sformatf("%s c%0d color_ok", name, k), write_color_ok,
                  twr && trs && k == last);
            check($sformatf("%s c%0d rvalid", name, k), rdata_valid, !twr && k == last);
            if (!twr && k == last)
                check($sformatf("%s rdata", name), rdata, exp_rd);
        end
        we = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check($sformatf("%s idle busy", name), busy, 1'b0);
        check($sformatf("%s idle cs_n", name), lcd_cs_n, 1'b1);
        check($sformatf("%s idle pulses", name),
              {init_write_ok, write_color_ok, rdata_valid}, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wr = 1'b0; lcd_rs = 1'b0; data = '0;
        id_fm = 1'b0; read_color = 1'b0; lcd_data_i = '0;
        repeat (3) step();
        rst_n = 1'b1;

        check("rst busy", busy, 1'b0);
        check("rst strobes", {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs_o}, 4'b1110);
        check("rst data_o", lcd_data_o, 16'h0000);
        check("rst oe", lcd_data_oe, 1'b0);
        check("rst rdata", rdata, 16'h0000);
        check("rst pulses", {init_write_ok, write_color_ok, rdata_valid}, 3'b000);

        // Command write with a stray we at cycle 3 that must be dropped.
        run_txn("cmdwr", 1'b1, 1'b0, 16'h002C, 1'b0, 1'b0, 16'h0, 16'h0, 3);
        step(); check_idle("cmdwr+1");
        step(); check_idle("cmdwr+2");

        // Data write, then a second write accepted on the first idle cycle.
        run_txn("datwr", 1'b1, 1'b1, 16'hF800, 1'b0, 1'b0, 16'h0, 16'h0, -1);
        step(); check_idle("datwr+1");
        run_txn("chain", 1'b1, 1'b1, 16'h07E0, 1'b0, 1'b0, 16'h0, 16'h0, -1);
        step(); check_idle("chain+1");

        run_txn("colrd", 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'hAAAA, 16'h1234, -1);
        step(); check_idle("colrd+1");
        check("colrd hold rdata", rdata, 16'h1234);

        run_txn("idrd", 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h9341, 16'hFFFF, -1);
        step(); check_idle("idrd+1");

        // Reset during WR_LO of a write.
        we = 1'b1; wr = 1'b1; lcd_rs = 1'b1; data = 16'h5555;
        step(); we = 1'b0;
        step();
        step();
        check("rstmid c3 wr_n", lcd_wr_n, 1'b0);
        rst_n = 1'b0;
        step();
        check("rstmid cs_n", lcd_cs_n, 1'b1);
        check("rstmid wr_n", lcd_wr_n, 1'b1);
        check("rstmid busy", busy, 1'b0);
        check("rstmid oe", lcd_data_oe, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rstmid post%0d", i),
                  {busy, init_write_ok, write_color_ok, lcd_cs_n}, 4'b0001);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Physical-bus timing engine for the 16-bit 8080-style parallel LCD port. It sits directly downstream of the init/id request mux and consumes the `interface_mux_struct` request fields: `data`, `we`, `wr`, `lcd_rs`, `id_fm` and `read_color`. It turns each accepted request into correctly timed CS/RS/WR/RD strobes, and returns `busy`, `write_color_ok`, `init_write_ok` and read data to the mux.

## Interface
Parameters:
- WR_LOW_CYC, 2, cycles `lcd_wr_n` is held low per write (≥1)
- WR_HIGH_CYC, 2, cycles `lcd_wr_n` is held high after the low phase (≥1)
- RD_LOW_CYC, 8, cycles `lcd_rd_n` is held low per read word (≥1)
- RD_HIGH_CYC, 8, cycles `lcd_rd_n` is held high after each read word (≥1)
- CNT_W, 4, phase counter width; must hold max(*_CYC)-1

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- we  in  1  request strobe; sampled only in IDLE
- wr  in  1  1 = write, 0 = read
- lcd_rs  in  1  0 = command, 1 = data
- data  in  16  write payload
- id_fm  in  1  read kind: 0 = ID, 1 = frame memory
- read_color  in  1  read needs a dummy word first
- busy  out  1  transaction in progress
- write_color_ok  out  1  one-cycle pulse when a data write (`lcd_rs=1`) completes
- init_write_ok  out  1  one-cycle pulse when any write completes
- rdata  out  16  last captured read word
- rdata_valid  out  1  one-cycle pulse when `rdata` is updated with the final read word
- lcd_cs_n, lcd_rs_o, lcd_wr_n, lcd_rd_n  out  1 each  panel strobes
- lcd_data_o  out  16  bus drive value
- lcd_data_oe  out  1  bus output enable (tristate control lives in top level)
- lcd_data_i  in  16  bus sample value

## Operation
- FSM states: IDLE, SETUP, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE:
  - `busy=0`.
  - `we=1` latches `wr`, `lcd_rs`, `data`, and the word count, then moves to SETUP.
  - Word count: 2 if `read_color` or `id_fm`, else 1. Writes always use 1.
- SETUP, 1 cycle:
  - `lcd_cs_n=0` and `lcd_rs_o` is driven from the latched value.
  - For a write, `lcd_data_o` = latched data and `lcd_data_oe=1`.
  - Next state is WR_LO for a write, RD_LO for a read.
- WR_LO: `lcd_wr_n=0` for WR_LOW_CYC cycles, then WR_HI.
- WR_HI: `lcd_wr_n=1` for WR_HIGH_CYC cycles, then DONE.
- RD_LO:
  - `lcd_data_oe=0` and `lcd_rd_n=0` for RD_LOW_CYC cycles.
  - `lcd_data_i` is registered on the last cycle of RD_LO.
- RD_HI:
  - `lcd_rd_n=1` for RD_HIGH_CYC cycles.
  - The remaining-word count then decrements. If nonzero, go to RD_LO; else go to DONE.
  - Only the final word is loaded into `rdata`; the dummy word is discarded.
- DONE, 1 cycle:
  - `lcd_cs_n=1` and `busy=0`.
  - Pulses `init_write_ok` (write), plus `write_color_ok` if `lcd_rs=1`, or `rdata_valid` (read).
  - Returns to IDLE.
- A `we` asserted in any state other than IDLE is ignored; no queueing.
- Phase counter: loads *_CYC-1 on state entry, decrements, and exits at 0. No wrap.

## Timing
- Reset values: `busy=0`, `lcd_cs_n=1`, `lcd_wr_n=1`, `lcd_rd_n=1`, `lcd_rs_o=0`, `lcd_data_o=0`, `lcd_data_oe=0`, `rdata=0`, all pulses 0, FSM=IDLE.
- All outputs are registered. `busy` rises the cycle after `we` is accepted.
- Write: accept at cycle 0.
  - SETUP is cycle 1.
  - `lcd_wr_n` is low for cycles 2..1+WR_LOW_CYC.
  - The ok pulse occurs at cycle 2+WR_LOW_CYC+WR_HIGH_CYC, which is 6 with defaults.
- Read of N words: the pulse occurs at cycle 2 + N·(RD_LOW_CYC+RD_HIGH_CYC), which is 34 for 2 words with defaults.
- A new `we` is accepted in the same cycle DONE→IDLE completes, i.e. the cycle after the ok pulse.
- `rst_n=0` mid-transaction returns to reset values on the next edge, with no ok pulse, and `lcd_cs_n` is released immediately.

## Structure
- Add to `lcd_types`:
  - enum `lcd_bus_state_t` (the 7 states above);
  - localparam defaults for the four timing values.
- The struct fields map 1:1 onto this block's ports; the top level connects them.
- One sub-module, `lcd_phase_timer`: loadable CNT_W down-counter with a `zero` flag.

## Test plan
- Command write, `wr=1`, `lcd_rs=0`, `data=16'h002C` at cycle 0:
  - `lcd_wr_n` is low cycles 2–3 with `lcd_data_o=16'h002C`, `oe=1`;
  - `init_write_ok` pulses at cycle 6; `write_color_ok` stays 0.
- Data write, `lcd_rs=1`, `data=16'hF800`: both ok pulses occur at cycle 6, and `busy` is high cycles 1–5.
- Color read, `read_color=1`, bench drives `16'hAAAA` on word 1 and `16'h1234` on word 2 → `rdata=16'h1234`, `rdata_valid` at cycle 34, `lcd_rd_n` has two low pulses of 8 cycles.
- Plain read, `id_fm=0`, `read_color=0`, bus `16'h9341` → a single RD pulse and `rdata=16'h9341` at cycle 18.
- `we` pulsed at cycle 3 during a write → ignored. A `we` immediately after the ok pulse is accepted, and its SETUP follows with no idle gap.
- `rst_n` low at cycle 3 of a write → the next edge gives `lcd_cs_n=1`, `lcd_wr_n=1`, `busy=0`, and no ok pulse is ever emitted.
